// File: rtl/sdrc_user_model.sv
// Block-RAM backed stand-in for the SDRAM controller user port.
// Define SDRC_USER_MODEL_CHECK_EN to add O_protocol_error and protocol checks.
module sdrc_user_model #(
    parameter int ADDRESS_BIT_WIDTH = 10,
    parameter int INIT_CYCLES       = 16,
    parameter int READ_LATENCY      = 4,
    parameter int BUSY_CYCLES       = 4
) (
    input  logic        I_sdrc_clk,
    input  logic        I_sdrc_rst_n,
    input  logic        I_sdrc_cmd_en,
    input  logic [2:0]  I_sdrc_cmd,
    input  logic        I_sdrc_precharge_ctrl,
    input  logic        I_sdram_power_down,
    input  logic        I_sdram_selfrefresh,
    input  logic [20:0] I_sdrc_addr,
    input  logic [3:0]  I_sdrc_dqm,
    input  logic [31:0] I_sdrc_data,
    input  logic [7:0]  I_sdrc_data_len,
    output logic [31:0] O_sdrc_data,
    output logic        O_sdrc_init_done,
    output logic        O_sdrc_cmd_ack
`ifdef SDRC_USER_MODEL_CHECK_EN
    ,
    output logic        O_protocol_error
`endif
);

    localparam int DEPTH = 1 << ADDRESS_BIT_WIDTH;

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_LMR = 3'b000;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WRITE, S_RDWAIT, S_READ, S_BUSY
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  beat_q, beat_d;
    logic [7:0]  col_q, col_d;
    logic [7:0]  len_q, len_d;
    logic        ap_q, ap_d;
    logic [3:0]  dqm_q, dqm_d;
    logic [1:0]  bank_q, bank_d;
    logic [10:0] row_q, row_d;
    logic        rv_q, rv_d;
    logic        init_q, init_d;
    logic        ack_q;
    logic [31:0] data_q;

    logic [31:0] mem_q [DEPTH];

    logic                         accept;
    logic                         we;
    logic                         rd_en;
    logic [7:0]                   acc_col;
    logic [3:0]                   wmask;
    logic [ADDRESS_BIT_WIDTH-1:0] mem_idx;

    assign accept = (state_q == S_IDLE) && I_sdrc_cmd_en
                  && (I_sdrc_cmd != CMD_NOP)
                  && !I_sdram_power_down && !I_sdram_selfrefresh;

    assign mem_idx = ADDRESS_BIT_WIDTH'({bank_q, row_q, acc_col});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        col_d   = col_q;
        len_d   = len_q;
        ap_d    = ap_q;
        dqm_d   = dqm_q;
        bank_d  = bank_q;
        row_d   = row_q;
        rv_d    = rv_q;
        init_d  = init_q;
        we      = 1'b0;
        rd_en   = 1'b0;
        acc_col = col_q + beat_q;
        wmask   = dqm_q;
        unique case (state_q)
            S_INIT: begin
                if (cnt_q == 16'(INIT_CYCLES - 1)) begin
                    init_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    unique case (I_sdrc_cmd)
                        CMD_ACT: begin
                            bank_d = I_sdrc_addr[20:19];
                            row_d  = I_sdrc_addr[18:8];
                            rv_d   = 1'b1;
                        end
                        CMD_WR: begin
                            // Word 0 rides in with the command itself.
                            we      = 1'b1;
                            acc_col = I_sdrc_addr[7:0];
                            wmask   = I_sdrc_dqm;
                            col_d   = I_sdrc_addr[7:0];
                            len_d   = I_sdrc_data_len;
                            ap_d    = I_sdrc_precharge_ctrl;
                            dqm_d   = I_sdrc_dqm;
                            beat_d  = 8'd1;
                            if (I_sdrc_data_len == 8'd0) begin
                                if (I_sdrc_precharge_ctrl) rv_d = 1'b0;
                            end else begin
                                state_d = S_WRITE;
                            end
                        end
                        CMD_RD: begin
                            col_d   = I_sdrc_addr[7:0];
                            len_d   = I_sdrc_data_len;
                            ap_d    = I_sdrc_precharge_ctrl;
                            beat_d  = 8'd0;
                            cnt_d   = '0;
                            state_d = S_RDWAIT;
                        end
                        CMD_PRE: begin
                            rv_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = S_BUSY;
                        end
                        CMD_REF, CMD_LMR: begin
                            cnt_d   = '0;
                            state_d = S_BUSY;
                        end
                        default: ;
                    endcase
                end
            end
            S_WRITE: begin
                we = 1'b1;
                if (beat_q == len_q) begin
                    state_d = S_IDLE;
                    if (ap_q) rv_d = 1'b0;
                end else begin
                    beat_d = beat_q + 8'd1;
                end
            end
            S_RDWAIT: begin
                // The last wait edge precedes the registered read of word 0.
                if (cnt_q == 16'(READ_LATENCY - 2)) begin
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_READ: begin
                rd_en = 1'b1;
                if (beat_q == len_q) begin
                    state_d = S_IDLE;
                    if (ap_q) rv_d = 1'b0;
                end else begin
                    beat_d = beat_q + 8'd1;
                end
            end
            S_BUSY: begin
                if (cnt_q == 16'(BUSY_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge I_sdrc_clk or negedge I_sdrc_rst_n) begin
        if (!I_sdrc_rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            beat_q  <= '0;
            col_q   <= '0;
            len_q   <= '0;
            ap_q    <= 1'b0;
            dqm_q   <= '0;
            bank_q  <= '0;
            row_q   <= '0;
            rv_q    <= 1'b0;
            init_q  <= 1'b0;
            ack_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            col_q   <= col_d;
            len_q   <= len_d;
            ap_q    <= ap_d;
            dqm_q   <= dqm_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            rv_q    <= rv_d;
            init_q  <= init_d;
            ack_q   <= accept;
            if (rd_en) data_q <= mem_q[mem_idx];
        end
    end

    // Contents survive reset, like the real SDRAM array.
    always_ff @(posedge I_sdrc_clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (!wmask[b]) mem_q[mem_idx][8*b +: 8] <= I_sdrc_data[8*b +: 8];
            end
        end
    end

    assign O_sdrc_data      = data_q;
    assign O_sdrc_init_done = init_q;
    assign O_sdrc_cmd_ack   = ack_q;

`ifdef SDRC_USER_MODEL_CHECK_EN
    logic perr_q;
    logic err_cmd, err_row, err_wrap, is_rw;

    assign is_rw    = (I_sdrc_cmd == CMD_RD) || (I_sdrc_cmd == CMD_WR);
    assign err_cmd  = I_sdrc_cmd_en && (I_sdrc_cmd != CMD_NOP)
                    && ((state_q != S_IDLE) || !init_q);
    assign err_row  = accept && is_rw && !rv_q;
    assign err_wrap = accept && is_rw
                    && (({1'b0, I_sdrc_addr[7:0]} + {1'b0, I_sdrc_data_len}) > 9'd255);

    always_ff @(posedge I_sdrc_clk or negedge I_sdrc_rst_n) begin
        if (!I_sdrc_rst_n) perr_q <= 1'b0;
        else               perr_q <= perr_q | err_cmd | err_row | err_wrap;
    end

    assign O_protocol_error = perr_q;

`ifndef SYNTHESIS
    always_ff @(posedge I_sdrc_clk) begin
        if (I_sdrc_rst_n) begin
            if (err_cmd)  $error("%0t: command while not ready", $time);
            if (err_row)  $error("%0t: read/write with no open row", $time);
            if (err_wrap) $error("%0t: burst column wraps past 255", $time);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_sdrc_user_model.sv
// Directed bench for sdrc_user_model: init, bursts, masking, wrap, ignores, reset.
module tb_sdrc_user_model;

    localparam int RL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  cmd;
    logic        apc;
    logic        pd;
    logic        sr;
    logic [20:0] addr;
    logic [3:0]  dqm;
    logic [31:0] wdat;
    logic [7:0]  len;
    logic [31:0] rdat;
    logic        init_done;
    logic        ack;
`ifdef SDRC_USER_MODEL_CHECK_EN
    logic        perr;
`endif

    int checks = 0;
    int fails  = 0;

    logic [31:0] wd [8];
    logic [31:0] ex [8];
    logic [31:0] exp_last = 32'h0;

    always #5 clk = ~clk;

    sdrc_user_model #(
        .ADDRESS_BIT_WIDTH(10),
        .INIT_CYCLES(16),
        .READ_LATENCY(RL),
        .BUSY_CYCLES(4)
    ) dut (
        .I_sdrc_clk(clk),
        .I_sdrc_rst_n(rst_n),
        .I_sdrc_cmd_en(en),
        .I_sdrc_cmd(cmd),
        .I_sdrc_precharge_ctrl(apc),
        .I_sdram_power_down(pd),
        .I_sdram_selfrefresh(sr),
        .I_sdrc_addr(addr),
        .I_sdrc_dqm(dqm),
        .I_sdrc_data(wdat),
        .I_sdrc_data_len(len),
        .O_sdrc_data(rdat),
        .O_sdrc_init_done(init_done),
        .O_sdrc_cmd_ack(ack)
`ifdef SDRC_USER_MODEL_CHECK_EN
        ,
        .O_protocol_error(perr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cmd_go(input logic [2:0] c, input logic [20:0] a, input logic [7:0] l,
                          input logic [3:0] m, input logic [31:0] d);
        en = 1'b1; cmd = c; addr = a; len = l; dqm = m; wdat = d;
        @(negedge clk);
        check("ack", {31'b0, ack}, 32'd1);
        en = 1'b0; cmd = 3'b111;
    endtask

    task automatic do_active(input logic [20:0] a);
        cmd_go(3'b011, a, 8'd0, 4'd0, 32'd0);
    endtask

    task automatic do_write(input logic [20:0] a, input int l, input logic [3:0] m);
        cmd_go(3'b100, a, 8'(l), m, wd[0]);
        for (int i = 1; i <= l; i++) begin
            wdat = wd[i];
            @(negedge clk);
        end
    endtask

    task automatic do_read(input logic [20:0] a, input int l, input bit noise);
        cmd_go(3'b101, a, 8'(l), 4'd0, 32'd0);
        if (noise) begin
            en = 1'b1; cmd = 3'b100;
        end
        repeat (RL - 1) @(negedge clk);
        check("lat", rdat, exp_last);
        for (int i = 0; i <= l; i++) begin
            @(negedge clk);
            check($sformatf("rd%0d", i), rdat, ex[i]);
            if (noise) check("noack", {31'b0, ack}, 32'd0);
        end
        en = 1'b0; cmd = 3'b111;
        exp_last = ex[l];
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cmd = 3'b111; apc = 1'b0; pd = 1'b0; sr = 1'b0;
        addr = '0; dqm = '0; wdat = '0; len = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_data", rdat, 32'd0);
        check("rst_init", {31'b0, init_done}, 32'd0);
        check("rst_ack", {31'b0, ack}, 32'd0);

        en = 1'b1; cmd = 3'b101;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("init%0d", k), {31'b0, init_done}, (k == 16) ? 32'd1 : 32'd0);
            check("init_ack", {31'b0, ack}, 32'd0);
        end
        en = 1'b0; cmd = 3'b111;

        // Row 0 burst write then read back
        do_active(21'h000);
        wd = '{32'h12345678, 32'habcdef01, 32'h56781010, 32'habcdfefe,
               32'habceef01, 32'habcdef02, 32'habcdef03, 32'habcdef04};
        do_write(21'h000, 7, 4'b0000);
        do_active(21'h000);
        ex = wd;
        do_read(21'h000, 7, 1'b0);

        // Row 1, partial read from col 4
        do_active(21'h100);
        wd[0] = 32'h10102020;
        do_write(21'h100, 7, 4'b0000);
        do_active(21'h100);
        ex = '{32'habceef01, 32'habcdef02, 32'habcdef03, 32'habcdef04,
               32'h0, 32'h0, 32'h0, 32'h0};
        do_read(21'h104, 3, 1'b0);
        do_active(21'h000);
        ex[0] = 32'h12345678;
        do_read(21'h000, 0, 1'b0);

        // Column wrap with byte mask
        do_active(21'h200);
        wd = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff,
               32'hffffffff, 32'h0, 32'h0, 32'h0};
        do_write(21'h2fe, 4, 4'b0000);
        wd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
               32'h0, 32'h0, 32'h0, 32'h0};
        do_write(21'h2fe, 3, 4'b1100);
        ex = '{32'hffff1111, 32'hffff2222, 32'hffff3333, 32'hffff4444,
               32'hffffffff, 32'h0, 32'h0, 32'h0};
        do_read(21'h2fe, 4, 1'b0);
        do_active(21'h100);
        ex[0] = 32'h10102020;
        do_read(21'h100, 0, 1'b0);
`ifdef SDRC_USER_MODEL_CHECK_EN
        check("perr", {31'b0, perr}, 32'd1);
`endif

        // Commands during a read burst are ignored
        do_active(21'h000);
        ex = '{32'h12345678, 32'habcdef01, 32'h56781010, 32'habcdfefe,
               32'h0, 32'h0, 32'h0, 32'h0};
        do_read(21'h000, 3, 1'b1);

        // Commands during refresh busy are ignored
        cmd_go(3'b001, 21'h0, 8'd0, 4'd0, 32'd0);
        en = 1'b1; cmd = 3'b101;
        repeat (2) begin
            @(negedge clk);
            check("busy_ack", {31'b0, ack}, 32'd0);
        end
        en = 1'b0; cmd = 3'b111;
        repeat (3) @(negedge clk);
        check("busy_data", rdat, exp_last);
        ex[0] = 32'h12345678;
        do_read(21'h000, 0, 1'b0);

        // Power-down blocks commands
        pd = 1'b1; en = 1'b1; cmd = 3'b101; addr = 21'h004;
        repeat (2) begin
            @(negedge clk);
            check("pd_ack", {31'b0, ack}, 32'd0);
            check("pd_data", rdat, exp_last);
        end
        en = 1'b0; cmd = 3'b111; pd = 1'b0;

        // Reset in the middle of a write burst
        do_active(21'h300);
        wd = '{32'ha0a0a0a0, 32'ha1a1a1a1, 32'ha2a2a2a2, 32'ha3a3a3a3,
               32'ha4a4a4a4, 32'ha5a5a5a5, 32'ha6a6a6a6, 32'ha7a7a7a7};
        cmd_go(3'b100, 21'h300, 8'd7, 4'b0000, wd[0]);
        wdat = wd[1];
        @(negedge clk);
        wdat = wd[2];
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_data", rdat, 32'd0);
        check("mid_init", {31'b0, init_done}, 32'd0);
        check("mid_ack", {31'b0, ack}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 32'h0;
        repeat (16) @(negedge clk);
        check("reinit", {31'b0, init_done}, 32'd1);
        do_active(21'h300);
        ex = '{32'ha0a0a0a0, 32'ha1a1a1a1, 32'ha2a2a2a2, 32'h0,
               32'h0, 32'h0, 32'h0, 32'h0};
        do_read(21'h300, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
